rc4_prga_decryptor: RTL

- Consumer end of the shuffled S memory. Runs the RC4 PRGA on the single-port S RAM after shuffle completes.
- XORs each keystream byte with the encrypted ROM byte and writes plaintext to the decrypted-message RAM.
- Sits after the shuffle and S-read stages. Started by the time controller; reports done back to it.

---
 rtl/rc4_prga_decryptor.sv | 112 +++++++++++
 1 files changed

// File: rtl/rc4_prga_decryptor.sv
// rc4_prga_decryptor: RC4 PRGA over the shuffled S RAM, XORs keystream with the encrypted ROM into the message RAM.
// Optional RC4_ASCII_CHECK_EN aborts on the first plaintext byte outside 'a'..'z' / space.
module rc4_prga_decryptor #(
    parameter int MSG_DEP = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [ADDR_W-1:0] enc_address,
    input  logic [7:0]        enc_q,
    output logic [ADDR_W-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic              busy,
    output logic              done,
    output logic              key_invalid
);
    typedef enum logic [3:0] {
        IDLE, RD_SI, WT_SI, CAP_SI, RD_SJ, WT_SJ, CAP_SJ,
        WR_SI, WR_SJ, RD_F, WT_F, CAP_F, WR_DEC, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_DEP - 1);

    state_t            state, state_n;
    logic [7:0]        i, j, si, sj, dec_byte, s_addr_q, f_byte;
    logic [ADDR_W-1:0] k, enc_addr_q, dec_addr_q;
    logic              start_ok, byte_ok;

    assign f_byte   = s_q ^ enc_q;
    assign start_ok = start && (state == IDLE || state == DONE);
`ifdef RC4_ASCII_CHECK_EN
    logic key_inv;
    assign byte_ok     = (f_byte >= 8'h61 && f_byte <= 8'h7a) || f_byte == 8'h20;
    assign key_invalid = key_inv;
`else
    assign byte_ok     = 1'b1;
    assign key_invalid = 1'b0;
`endif

    // Addresses hold their last driven value between access states
    always_comb begin
        s_address   = state == RD_SI ? i + 8'd1 :
                      (state == RD_SJ || state == WR_SJ) ? j :
                      state == WR_SI ? i :
                      state == RD_F ? si + sj : s_addr_q;
        s_data      = state == WR_SI ? sj : state == WR_SJ ? si : 8'd0;
        s_wren      = state == WR_SI || state == WR_SJ;
        enc_address = state == RD_F ? k : enc_addr_q;
        dec_address = state == WR_DEC ? k : dec_addr_q;
        dec_data    = state == WR_DEC ? dec_byte : 8'd0;
        dec_wren    = state == WR_DEC;
        busy        = state != IDLE && state != DONE;
        done        = state == DONE;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? RD_SI : state;
            CAP_F:      state_n = byte_ok ? WR_DEC : DONE;
            WR_DEC:     state_n = k == K_LAST ? DONE : RD_SI;
            default:    state_n = state_t'(state + 4'd1);
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            si         <= '0;
            sj         <= '0;
            dec_byte   <= '0;
            s_addr_q   <= '0;
            enc_addr_q <= '0;
            dec_addr_q <= '0;
        end else begin
            state      <= state_n;
            s_addr_q   <= s_address;
            enc_addr_q <= enc_address;
            dec_addr_q <= dec_address;
            if (start_ok) begin
                i <= '0;
                j <= '0;
                k <= '0;
            end
            if (state == RD_SI) i <= i + 8'd1;
            if (state == CAP_SI) begin
                si <= s_q;
                j  <= j + s_q;
            end
            if (state == CAP_SJ) sj <= s_q;
            if (state == CAP_F) dec_byte <= f_byte;
            if (state == WR_DEC && k != K_LAST) k <= k + 1'b1;
        end
    end

`ifdef RC4_ASCII_CHECK_EN
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) key_inv <= 1'b0;
        else if (start_ok) key_inv <= 1'b0;
        else if (state == CAP_F && !byte_ok) key_inv <= 1'b1;
    end
`endif
endmodule
